// File: rtl/ones_pkg.sv
// Shared types and default widths for the ones stream generator.
// The FSM states and parameter defaults live here so every file agrees on them.
package ones_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/intf_gen.sv
// Bundle of the generator's signals with clocking blocks for driving and monitoring.
// The DUT sees plain signals through the dut modport.
interface intf_gen
    import ones_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk
);
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] req_len;
    logic [LEN_W-1:0] req_ones;
    logic             data;
    logic             data_valid;
    logic [CNT_W-1:0] exp_count;
    logic             done;
    logic             err;

    clocking drv_cb @(posedge clk);
        output reset, req_valid, req_len, req_ones;
        input  req_ready, data, data_valid, exp_count, done, err;
    endclocking

    clocking mon_cb @(posedge clk);
        input reset, req_valid, req_ready, req_len, req_ones;
        input data, data_valid, exp_count, done, err;
    endclocking

    modport dut (
        input  clk, reset, req_valid, req_len, req_ones,
        output req_ready, data, data_valid, exp_count, done, err
    );

endinterface

// File: rtl/ones_spread_acc.sv
// Bresenham-style accumulator that spreads `ones` ones evenly over `len` bits,
// plus the bit index that flags the last bit of the stream.
module ones_spread_acc
    import ones_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [LEN_W-1:0] len_in,
    input  logic [LEN_W-1:0] ones_in,
    output logic             bit_out,
    output logic             last
);
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] ones_q;
    logic [LEN_W:0]   acc_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W:0]   sum;

    // acc stays below len, so acc + ones always fits in LEN_W+1 bits.
    always_comb begin
        sum     = acc_q + {1'b0, ones_q};
        bit_out = (sum >= {1'b0, len_q});
        last    = (idx_q == (len_q - LEN_W'(1)));
    end

    // NOTE: non-blocking assignments for every register so all flops update
    // together from pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= '0;
            ones_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (load) begin
            len_q  <= len_in;
            ones_q <= ones_in;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (step) begin
            acc_q <= bit_out ? (sum - {1'b0, len_q}) : sum;
            idx_q <= idx_q + LEN_W'(1);
        end
    end

endmodule

// File: rtl/ones_stream_gen.sv
// Emits a serial stream of req_len bits containing exactly req_ones ones, plus
// the running ones tally a downstream ones counter is expected to show.
module ones_stream_gen
    import ones_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic [LEN_W-1:0] req_ones,
    output logic             data,
    output logic             data_valid,
    output logic [CNT_W-1:0] exp_count,
    output logic             done,
    output logic             err
);
    state_t state_q, state_d;
    logic   accept;
    logic   reject;
    logic   acc_bit;
    logic   last;

    ones_spread_acc #(.LEN_W(LEN_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (data_valid),
        .len_in  (req_len),
        .ones_in (req_ones),
        .bit_out (acc_bit),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        data_valid = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if ((req_len == '0) || (req_ones > req_len)) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                data_valid = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        data = data_valid & acc_bit;
    end

    // The tally lags the bit by one cycle, matching a registered ones counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_count <= '0;
            err       <= 1'b0;
        end else begin
            err <= reject;
            if (accept)    exp_count <= '0;
            else if (data) exp_count <= exp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ones_stream_gen.sv
// Directed bench for ones_stream_gen: a table of requests with hand-computed
// bit patterns, then reset-abort and back-to-back sequences.
module tb_ones_stream_gen;
    import ones_pkg::*;

    localparam int LEN_W = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [LEN_W-1:0] ones;
        logic [31:0]      pattern;   // expected bits, first bit in bit 0
        logic [CNT_W-1:0] final_cnt;
        logic             is_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    intf_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) gif (.clk(clk));

    ones_stream_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (gif.reset),
        .req_valid  (gif.req_valid),
        .req_ready  (gif.req_ready),
        .req_len    (gif.req_len),
        .req_ones   (gif.req_ones),
        .data       (gif.data),
        .data_valid (gif.data_valid),
        .exp_count  (gif.exp_count),
        .done       (gif.done),
        .err        (gif.err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs set here
    // are picked up at the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input vec_t v, input int idx);
        logic [CNT_W-1:0] model_cnt;
        model_cnt = '0;
        check($sformatf("v%0d ready_at_req", idx), {31'b0, gif.req_ready}, 32'd1);
        gif.req_valid = 1'b1;
        gif.req_len   = v.len;
        gif.req_ones  = v.ones;
        step();
        gif.req_valid = 1'b0;
        gif.req_len   = '0;
        gif.req_ones  = '0;
        if (v.is_err) begin
            check($sformatf("v%0d err_pulse", idx), {31'b0, gif.err}, 32'd1);
            check($sformatf("v%0d no_valid", idx), {31'b0, gif.data_valid}, 32'd0);
            check($sformatf("v%0d ready_kept", idx), {31'b0, gif.req_ready}, 32'd1);
            step();
            check($sformatf("v%0d err_single", idx), {31'b0, gif.err}, 32'd0);
            check($sformatf("v%0d no_valid2", idx), {31'b0, gif.data_valid}, 32'd0);
        end else begin
            for (int i = 0; i < int'(v.len); i++) begin
                check($sformatf("v%0d valid[%0d]", idx, i), {31'b0, gif.data_valid}, 32'd1);
                check($sformatf("v%0d data[%0d]", idx, i), {31'b0, gif.data}, {31'b0, v.pattern[i]});
                check($sformatf("v%0d cnt[%0d]", idx, i), {28'b0, gif.exp_count}, {28'b0, model_cnt});
                if (gif.data_valid && gif.data) model_cnt = model_cnt + 1'b1;
                step();
            end
            check($sformatf("v%0d done", idx), {31'b0, gif.done}, 32'd1);
            check($sformatf("v%0d done_valid", idx), {31'b0, gif.data_valid}, 32'd0);
            check($sformatf("v%0d done_data", idx), {31'b0, gif.data}, 32'd0);
            check($sformatf("v%0d final_cnt", idx), {28'b0, gif.exp_count}, {28'b0, v.final_cnt});
            check($sformatf("v%0d counter_model", idx), {28'b0, gif.exp_count}, {28'b0, model_cnt});
            step();
            check($sformatf("v%0d done_single", idx), {31'b0, gif.done}, 32'd0);
            check($sformatf("v%0d ready_after", idx), {31'b0, gif.req_ready}, 32'd1);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int done_cyc;
        int first2;
        int waited;

        vecs[0] = '{len: 8'd8,  ones: 8'd4,  pattern: 32'h000000AA, final_cnt: 4'd4, is_err: 1'b0};
        vecs[1] = '{len: 8'd5,  ones: 8'd0,  pattern: 32'h00000000, final_cnt: 4'd0, is_err: 1'b0};
        vecs[2] = '{len: 8'd5,  ones: 8'd5,  pattern: 32'h0000001F, final_cnt: 4'd5, is_err: 1'b0};
        vecs[3] = '{len: 8'd3,  ones: 8'd4,  pattern: 32'h00000000, final_cnt: 4'd0, is_err: 1'b1};
        vecs[4] = '{len: 8'd0,  ones: 8'd0,  pattern: 32'h00000000, final_cnt: 4'd0, is_err: 1'b1};
        vecs[5] = '{len: 8'd20, ones: 8'd18, pattern: 32'h000FFBFE, final_cnt: 4'd2, is_err: 1'b0};
        vecs[6] = '{len: 8'd1,  ones: 8'd1,  pattern: 32'h00000001, final_cnt: 4'd1, is_err: 1'b0};
        vecs[7] = '{len: 8'd3,  ones: 8'd2,  pattern: 32'h00000006, final_cnt: 4'd2, is_err: 1'b0};

        gif.reset     = 1'b1;
        gif.req_valid = 1'b0;
        gif.req_len   = '0;
        gif.req_ones  = '0;
        step();
        step();
        check("rst ready", {31'b0, gif.req_ready}, 32'd1);
        check("rst valid", {31'b0, gif.data_valid}, 32'd0);
        check("rst data", {31'b0, gif.data}, 32'd0);
        check("rst done", {31'b0, gif.done}, 32'd0);
        check("rst err", {31'b0, gif.err}, 32'd0);
        check("rst cnt", {28'b0, gif.exp_count}, 32'd0);
        gif.reset = 1'b0;
        step();

        for (int k = 0; k < 8; k++) run_req(vecs[k], k);

        // Reset during the third bit of a len=10 stream abandons it without done.
        check("abort ready", {31'b0, gif.req_ready}, 32'd1);
        gif.req_valid = 1'b1;
        gif.req_len   = 8'd10;
        gif.req_ones  = 8'd5;
        step();
        gif.req_valid = 1'b0;
        step();
        step();
        check("abort bit3 valid", {31'b0, gif.data_valid}, 32'd1);
        gif.reset = 1'b1;
        step();
        check("abort valid", {31'b0, gif.data_valid}, 32'd0);
        check("abort data", {31'b0, gif.data}, 32'd0);
        check("abort done", {31'b0, gif.done}, 32'd0);
        check("abort err", {31'b0, gif.err}, 32'd0);
        check("abort cnt", {28'b0, gif.exp_count}, 32'd0);
        check("abort ready_after", {31'b0, gif.req_ready}, 32'd1);
        gif.reset = 1'b0;
        step();
        check("abort no_late_done", {31'b0, gif.done}, 32'd0);
        run_req(vecs[0], 100);

        // Back-to-back: req_valid held high across two streams of len=4, ones=2.
        gif.req_valid = 1'b1;
        gif.req_len   = 8'd4;
        gif.req_ones  = 8'd2;
        done_cyc = -1;
        first2   = -1;
        for (int c = 0; c < 40 && first2 < 0; c++) begin
            step();
            if (gif.done && done_cyc < 0) done_cyc = c;
            else if (gif.data_valid && done_cyc >= 0 && first2 < 0) first2 = c;
        end
        gif.req_valid = 1'b0;
        gif.req_len   = '0;
        gif.req_ones  = '0;
        check("b2b seen", {31'b0, (done_cyc >= 0 && first2 >= 0)}, 32'd1);
        check("b2b gap", 32'(first2 - done_cyc), 32'd2);
        check("b2b first_bit", {31'b0, gif.data}, 32'd0);
        check("b2b cnt_restart", {28'b0, gif.exp_count}, 32'd0);
        waited = 0;
        while (!gif.done && waited < 40) begin
            step();
            waited++;
        end
        check("b2b second_done", {31'b0, gif.done}, 32'd1);
        check("b2b second_cnt", {28'b0, gif.exp_count}, 32'd2);
        step();
        check("b2b idle", {31'b0, gif.req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
